fdl_step_ctrl: RTL

- Parametrised digital controller for the fine delay line in the FMDLL.
- Filters phase-detector up/dn decisions and steps a thermometer code (ones fill from MSB) over N_STEPS+1 positions.
- Emits the matching one-hot drive-select vector.
- Hands overflow/underflow to the coarse stage through a req/ack carry handshake and flags lock after sustained dithering.

---
 rtl/fdl_step_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fdl_step_ctrl.sv
// -----------------------------------------------------------------------------
// fdl_step_ctrl - fine delay line step controller for the FMDLL
//
// Filters phase-detector up/dn decisions and steps a thermometer code
// (ones fill from the MSB) over N_STEPS+1 positions. Overflow/underflow is
// handed to the coarse stage through a carry_req/carry_ack handshake, and
// lock is flagged once the step direction has reversed LOCK_REV times in a row.
//
// Optional build macro: FDL_STEP_LOCK_FREEZE_EN
//   defined   - in LOCKED the filter needs 2*FILT_LEN net decisions per step
//   undefined - LOCKED filters exactly like TRACK (FILT_LEN decisions)
//
// Ports:
//   clk_in     in   controller clock
//   rst        in   asynchronous reset, active-high
//   en         in   loop enable; low freezes filter, code and lock
//   up / dn    in   phase detector: increase / decrease delay
//   carry_ack  in   coarse stage accepted the carry
//   q          out  thermometer code, code k sets the top k bits
//   code_oh    out  one-hot select, bit k set for code k
//   code_bin   out  binary code
//   carry_req  out  carry pending to coarse stage
//   carry_dir  out  1 = overflow (coarse +1), 0 = underflow (coarse -1)
//   lock       out  fine loop locked
// -----------------------------------------------------------------------------
module fdl_step_ctrl #(
   parameter int N_STEPS  = 6,
   parameter int FILT_LEN = 4,
   parameter int LOCK_REV = 4,
   parameter int RST_CODE = 0
) (
   input  logic                         clk_in,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         up,
   input  logic                         dn,
   input  logic                         carry_ack,
   output logic [N_STEPS-1:0]           q,
   output logic [N_STEPS:0]             code_oh,
   output logic [$clog2(N_STEPS+1)-1:0] code_bin,
   output logic                         carry_req,
   output logic                         carry_dir,
   output logic                         lock
);

   localparam int CW = $clog2(N_STEPS + 1);
   // Accumulator is sized for the widest threshold so both builds share it.
   localparam int AW = $clog2(2 * FILT_LEN) + 1;
   localparam int RW = $clog2(LOCK_REV + 1);

   localparam logic [CW-1:0]        MAX_CODE  = CW'(N_STEPS);
   localparam logic [CW-1:0]        INIT_CODE = CW'(RST_CODE);
   localparam logic [CW-1:0]        CODE_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]        CODE_ONE  = CW'(1);
   localparam logic [RW-1:0]        REV_SAT   = RW'(LOCK_REV);
   localparam logic [RW-1:0]        REV_ZERO  = {RW{1'b0}};
   localparam logic [RW-1:0]        REV_ONE   = RW'(1);
   localparam logic signed [AW-1:0] ACC_ZERO  = {AW{1'b0}};
   localparam logic signed [AW-1:0] ACC_ONE   = AW'(1);
   localparam logic signed [AW-1:0] THR_BASE  = AW'(FILT_LEN - 1);
`ifdef FDL_STEP_LOCK_FREEZE_EN
   localparam logic signed [AW-1:0] THR_LOCK  = AW'(2 * FILT_LEN - 1);
`else
   localparam logic signed [AW-1:0] THR_LOCK  = AW'(FILT_LEN - 1);
`endif

   typedef enum logic [1:0] {
      TRACK  = 2'd0,
      LOCKED = 2'd1,
      CARRY  = 2'd2
   } state_t;

   // Code k sets the top k bits of the thermometer word.
   function automatic logic [N_STEPS-1:0] therm_of(input logic [CW-1:0] k);
      logic [N_STEPS-1:0] t;
      t = {N_STEPS{1'b0}};
      for (int i = 0; i < N_STEPS; i++) begin
         t[i] = (int'(k) >= (N_STEPS - i));
      end
      return t;
   endfunction

   function automatic logic [N_STEPS:0] onehot_of(input logic [CW-1:0] k);
      logic [N_STEPS:0] o;
      o = {(N_STEPS + 1){1'b0}};
      for (int i = 0; i <= N_STEPS; i++) begin
         o[i] = (int'(k) == i);
      end
      return o;
   endfunction

   state_t                 state_q, state_d;
   logic [CW-1:0]          code_q, code_d;
   logic [N_STEPS-1:0]     q_q, q_d;
   logic [N_STEPS:0]       oh_q, oh_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic                   req_q, req_d;
   logic                   dir_q, dir_d;
   logic                   lock_q, lock_d;
   logic [RW-1:0]          rev_q, rev_d;
   logic                   last_q, last_d;
   logic                   seen_q, seen_d;   // a step has happened since reset

   logic                   step_up, step_dn;
   logic signed [AW-1:0]   thr_pos, thr_neg;
   logic [RW-1:0]          rev_inc;

   // Next-state: decision filter, code stepping, carry handshake, lock tracking.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      acc_d   = acc_q;
      req_d   = req_q;
      dir_d   = dir_q;
      lock_d  = lock_q;
      rev_d   = rev_q;
      last_d  = last_q;
      seen_d  = seen_q;
      step_up = 1'b0;
      step_dn = 1'b0;
      thr_pos = (state_q == LOCKED) ? THR_LOCK : THR_BASE;
      thr_neg = -thr_pos;
      rev_inc = (rev_q == REV_SAT) ? REV_SAT : rev_q + REV_ONE;

      case (state_q)
         CARRY: begin
            // Decisions and en are ignored while the coarse stage is busy.
            acc_d = ACC_ZERO;
            if (carry_ack) begin
               code_d  = dir_q ? CODE_ZERO : MAX_CODE;
               req_d   = 1'b0;
               lock_d  = 1'b0;
               rev_d   = REV_ZERO;
               state_d = TRACK;
            end else begin
               req_d = 1'b1;
            end
         end
         TRACK, LOCKED: begin
            if (!en) begin
               acc_d = acc_q;
            end else if (up && !dn) begin
               if (acc_q == thr_pos) begin
                  step_up = 1'b1;
                  acc_d   = ACC_ZERO;
               end else begin
                  acc_d = acc_q + ACC_ONE;
               end
            end else if (dn && !up) begin
               if (acc_q == thr_neg) begin
                  step_dn = 1'b1;
                  acc_d   = ACC_ZERO;
               end else begin
                  acc_d = acc_q - ACC_ONE;
               end
            end else begin
               acc_d = acc_q;
            end
         end
         default: begin
            state_d = TRACK;
         end
      endcase

      // A step past either end becomes a carry; the code waits for the ack.
      if (step_up && (code_q == MAX_CODE)) begin
         req_d   = 1'b1;
         dir_d   = 1'b1;
         state_d = CARRY;
      end else if (step_dn && (code_q == CODE_ZERO)) begin
         req_d   = 1'b1;
         dir_d   = 1'b0;
         state_d = CARRY;
      end else if (step_up || step_dn) begin
         code_d = step_up ? code_q + CODE_ONE : code_q - CODE_ONE;
         last_d = step_up;
         seen_d = 1'b1;
         if (!seen_q) begin
            rev_d = REV_ZERO;
         end else if (step_up != last_q) begin
            rev_d = rev_inc;
            if (rev_inc == REV_SAT) begin
               lock_d  = 1'b1;
               state_d = LOCKED;
            end else begin
               lock_d = lock_q;
            end
         end else begin
            // Loss of dither: a loop that was locked restarts counting at one.
            rev_d   = lock_q ? REV_ONE : REV_ZERO;
            lock_d  = 1'b0;
            state_d = TRACK;
         end
      end else begin
         last_d = last_q;
      end

      q_d  = therm_of(code_d);
      oh_d = onehot_of(code_d);
   end

   // State and output registers; all decoded views load from the same next code.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= TRACK;
         code_q  <= INIT_CODE;
         q_q     <= therm_of(INIT_CODE);
         oh_q    <= onehot_of(INIT_CODE);
         acc_q   <= ACC_ZERO;
         req_q   <= 1'b0;
         dir_q   <= 1'b0;
         lock_q  <= 1'b0;
         rev_q   <= REV_ZERO;
         last_q  <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         q_q     <= q_d;
         oh_q    <= oh_d;
         acc_q   <= acc_d;
         req_q   <= req_d;
         dir_q   <= dir_d;
         lock_q  <= lock_d;
         rev_q   <= rev_d;
         last_q  <= last_d;
         seen_q  <= seen_d;
      end
   end

   assign q         = q_q;
   assign code_oh   = oh_q;
   assign code_bin  = code_q;
   assign carry_req = req_q;
   assign carry_dir = dir_q;
   assign lock      = lock_q;

endmodule
